// File: rtl/roxxon_pkg.sv
// rtl/roxxon_pkg.sv - shared state encoding and sizing for the SIMD fetch path
package roxxon_pkg;

  localparam int N = 16;
  localparam int REGN = 512;
  localparam int PCW = $clog2(REGN / 2);
  localparam logic [31:0] HALT_OP = 32'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_LOAD_A,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT
  } seq_state_t;

endpackage

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - modulo-N row counter with clear, enable and terminal count
module mod_n_counter #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(N - 1));

  // Wrapping on the terminal row leaves the counter at 0 for the next phase.
  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - load/fetch/execute/writeback sequencer for the SIMD fetch unit
module fetch_sequencer #(
  parameter int N = roxxon_pkg::N,
  parameter int REGN = roxxon_pkg::REGN,
  parameter logic [31:0] ADDR = 32'h0000_0000,
  parameter logic [31:0] HALT_OP = roxxon_pkg::HALT_OP,
  localparam int RW = $clog2(N),
  localparam int PCW = $clog2(REGN / 2)
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           START,
  input  logic           MAT_VALID,
  output logic           LOAD_EN,
  output logic           MATAB_SEL,
  output logic [RW-1:0]  ROW_IDX,
  output logic           INSTR_REQ,
  output logic [PCW-1:0] PC_INS,
  input  logic           INSTR_VALID,
  input  logic [31:0]    INSTR,
  output logic [31:0]    INSTR_REG,
  output logic           EXEC_START,
  input  logic           EXEC_DONE,
  output logic           DOUT_MUX,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic           BUSY,
  output logic           DONE
);

  import roxxon_pkg::*;

  localparam logic [PCW-1:0] PC_ADDR = ADDR[PCW-1:0];
  localparam logic [PCW-1:0] PC_LAST = PCW'(REGN / 2 - 1);

  seq_state_t state, state_nxt;
  logic       cnt_clr, cnt_en, row_tc;
  logic       pc_inc, pc_load, ir_load, exec_start_nxt;

  mod_n_counter #(.N(N), .W(RW)) u_row_cnt (
    .CLK   (CLK),
    .rst   (RSTN),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (ROW_IDX),
    .tc    (row_tc)
  );

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      PC_INS     <= PC_ADDR;
      INSTR_REG  <= '0;
      EXEC_START <= 1'b0;
    end else begin
      EXEC_START <= exec_start_nxt;
      if (ir_load) begin
        INSTR_REG <= INSTR;
      end
      if (pc_load) begin
        PC_INS <= PC_ADDR;
      end else if (pc_inc) begin
        PC_INS <= (PC_INS == PC_LAST) ? '0 : PC_INS + PCW'(1);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    pc_inc         = 1'b0;
    pc_load        = 1'b0;
    ir_load        = 1'b0;
    exec_start_nxt = 1'b0;
    LOAD_EN        = 1'b0;
    MATAB_SEL      = 1'b0;
    INSTR_REQ      = 1'b0;
    DOUT_MUX       = 1'b0;
    OUT_VALID      = 1'b0;
    BUSY           = 1'b1;
    DONE           = 1'b0;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          state_nxt = S_LOAD_B;
          cnt_clr   = 1'b1;
        end
      end
      S_LOAD_B: begin
        LOAD_EN = MAT_VALID;
        cnt_en  = MAT_VALID;
        if (MAT_VALID && row_tc) begin
          state_nxt = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        MATAB_SEL = 1'b1;
        LOAD_EN   = MAT_VALID;
        cnt_en    = MAT_VALID;
        if (MAT_VALID && row_tc) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        INSTR_REQ = 1'b1;
        if (INSTR_VALID) begin
          ir_load = 1'b1;
          if (INSTR == HALT_OP) begin
            state_nxt = S_HALT;
          end else begin
            state_nxt      = S_EXEC;
            exec_start_nxt = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (EXEC_DONE) begin
          state_nxt = S_WB;
          cnt_clr   = 1'b1;
        end
      end
      S_WB: begin
        // Row index only moves on an accepted transfer, so a stalled row is held.
        DOUT_MUX  = 1'b1;
        OUT_VALID = 1'b1;
        cnt_en    = OUT_READY;
        if (OUT_READY && row_tc) begin
          state_nxt = S_FETCH;
          pc_inc    = 1'b1;
        end
      end
      S_HALT: begin
        BUSY = 1'b0;
        DONE = 1'b1;
        if (START) begin
          state_nxt = S_LOAD_B;
          cnt_clr   = 1'b1;
          pc_load   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam int N = 16;
  localparam int REGN = 512;
  localparam int PCW = 8;

  logic CLK = 1'b0;
  logic RSTN = 1'b1;
  logic START = 1'b0, MAT_VALID = 1'b0, INSTR_VALID = 1'b0, EXEC_DONE = 1'b0, OUT_READY = 1'b0;
  logic [31:0] INSTR = '0;
  logic LOAD_EN, MATAB_SEL, INSTR_REQ, EXEC_START, DOUT_MUX, OUT_VALID, BUSY, DONE;
  logic [3:0] ROW_IDX;
  logic [PCW-1:0] PC_INS;
  logic [31:0] INSTR_REG;

  fetch_sequencer dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .MAT_VALID(MAT_VALID),
    .LOAD_EN(LOAD_EN), .MATAB_SEL(MATAB_SEL), .ROW_IDX(ROW_IDX),
    .INSTR_REQ(INSTR_REQ), .PC_INS(PC_INS), .INSTR_VALID(INSTR_VALID),
    .INSTR(INSTR), .INSTR_REG(INSTR_REG), .EXEC_START(EXEC_START),
    .EXEC_DONE(EXEC_DONE), .DOUT_MUX(DOUT_MUX), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  int mat_p, rdy_p, iv_p, start_p, exec_dly, stall_left, stepn;
  int ecnt = -1;
  bit noise, go, toggle, stall3, wrap_halt, saw_top;
  logic [31:0] prog [256];
  int st_load_en, st_load_en_a, st_lb, st_exec, st_rows, st_stall3;
  int wb_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: rows loaded counts across both matrices (0..2N-1); rows out 0..N-1.
  typedef enum int {M_IDLE, M_LOAD, M_FETCH, M_EXEC, M_WB, M_HALT} mmode_t;
  mmode_t m_mode = M_IDLE;
  int m_rows = 0, m_pc = 0;
  logic [31:0] m_ireg = '0;
  bit m_pulse = 0, m_ok = 0;

  always @(posedge CLK) begin
    if (RSTN) begin
      m_mode <= M_IDLE; m_rows <= 0; m_pc <= 0; m_ireg <= '0; m_pulse <= 0; m_ok <= 1;
    end else begin
      m_pulse <= 0;
      case (m_mode)
        M_IDLE: if (START) begin m_mode <= M_LOAD; m_rows <= 0; end
        M_LOAD: if (MAT_VALID) begin
          if (m_rows == 2 * N - 1) begin m_mode <= M_FETCH; m_rows <= 0; end
          else m_rows <= m_rows + 1;
        end
        M_FETCH: if (INSTR_VALID) begin
          m_ireg <= INSTR;
          if (INSTR == 32'd0) m_mode <= M_HALT;
          else begin m_mode <= M_EXEC; m_pulse <= 1; end
        end
        M_EXEC: if (EXEC_DONE) begin m_mode <= M_WB; m_rows <= 0; end
        M_WB: if (OUT_READY) begin
          if (m_rows == N - 1) begin
            m_mode <= M_FETCH; m_rows <= 0; m_pc <= (m_pc + 1) % (REGN / 2);
          end else m_rows <= m_rows + 1;
        end
        M_HALT: if (START) begin m_mode <= M_LOAD; m_rows <= 0; m_pc <= 0; end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge CLK) begin
    logic [7:0] ef;
    if (m_ok) begin
      ef = {(m_mode == M_LOAD) && MAT_VALID, (m_mode == M_LOAD) && (m_rows >= N),
            m_mode == M_FETCH, m_pulse, m_mode == M_WB, m_mode == M_WB,
            m_mode inside {M_LOAD, M_FETCH, M_EXEC, M_WB}, m_mode == M_HALT};
      chk("ctrl_flags", 32'({LOAD_EN, MATAB_SEL, INSTR_REQ, EXEC_START, DOUT_MUX, OUT_VALID, BUSY, DONE}), 32'(ef));
      chk("row_idx", 32'(ROW_IDX), 32'(m_rows % N));
      chk("pc_ins", 32'(PC_INS), 32'(m_pc));
      chk("instr_reg", INSTR_REG, m_ireg);
      if (OUT_VALID && OUT_READY && !RSTN) begin
        chk("wb_row_order", 32'(ROW_IDX), 32'(wb_seen % N));
        wb_seen++; st_rows++;
      end
      if (LOAD_EN) st_load_en++;
      if (LOAD_EN && MATAB_SEL) st_load_en_a++;
      if (BUSY && !MATAB_SEL && !INSTR_REQ && !OUT_VALID) st_lb++;
      if (EXEC_START) st_exec++;
      if (OUT_VALID && !OUT_READY && ROW_IDX == 4'd3) st_stall3++;
    end
    if (RSTN) wb_seen = 0;
  end

  task automatic step();
    @(posedge CLK); #1;
    stepn++;
    START = go ? 1'b1 : ($urandom_range(99) < start_p);
    go = 0;
    MAT_VALID = toggle ? (stepn % 2 == 0) : ($urandom_range(99) < mat_p);
    OUT_READY = ($urandom_range(99) < rdy_p);
    if (stall3 && OUT_VALID && ROW_IDX == 4'd3 && stall_left > 0) begin
      OUT_READY = 1'b0; stall_left--;
    end
    if (wrap_halt) begin
      if (PC_INS == 8'd255) saw_top = 1;
      if (saw_top && PC_INS == 8'd0) prog[0] = 32'd0;
    end
    INSTR_VALID = INSTR_REQ ? ($urandom_range(99) < iv_p) : (noise && $urandom_range(7) == 0);
    INSTR = prog[PC_INS];
    if (EXEC_START) ecnt = exec_dly;
    else if (ecnt >= 0) ecnt--;
    EXEC_DONE = (ecnt == 0) || (noise && $urandom_range(7) == 0);
  endtask

  task automatic do_reset();
    mat_p = 100; rdy_p = 100; iv_p = 100; start_p = 0; exec_dly = 1;
    noise = 0; toggle = 0; wrap_halt = 0; stall3 = 0; go = 0; ecnt = -1;
    RSTN = 1'b1; step(); RSTN = 1'b0;
  endtask

  task automatic clr_stats();
    st_load_en = 0; st_load_en_a = 0; st_lb = 0; st_exec = 0; st_rows = 0; st_stall3 = 0;
  endtask

  task automatic run_to_done(input int budget, input string nm);
    int k = 0;
    while (!DONE && k < budget) begin step(); k++; end
    chk(nm, 32'(DONE), 32'd1);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) prog[i] = 32'h1;

    // Full-speed load: 32 rows, FETCH visible on cycle 33
    do_reset(); clr_stats(); go = 1; step();
    k = 0;
    while (!INSTR_REQ && k < 100) begin step(); k++; end
    chk("load_to_fetch_cycles", 32'(k), 32'd33);
    chk("load_en_cycles", 32'(st_load_en), 32'd32);
    chk("load_en_a_cycles", 32'(st_load_en_a), 32'd16);

    // Toggled MAT_VALID: LOAD_B spans 32 cycles for 16 rows
    do_reset(); clr_stats(); toggle = 1; stepn = -1; go = 1; step();
    k = 0;
    while (!MATAB_SEL && k < 100) begin step(); k++; end
    chk("load_b_cycles", 32'(st_lb), 32'd32);
    chk("load_b_rows", 32'(st_load_en), 32'd16);
    toggle = 0;

    // Reset mid LOAD_A at row 5
    do_reset(); go = 1; step();
    k = 0;
    while (!(MATAB_SEL && ROW_IDX == 4'd5) && k < 100) begin step(); k++; end
    chk("reach_load_a_row5", 32'({MATAB_SEL, ROW_IDX}), 32'h15);
    RSTN = 1'b1; step(); RSTN = 1'b0;
    chk("rst_flags", 32'({LOAD_EN, MATAB_SEL, INSTR_REQ, EXEC_START, DOUT_MUX, OUT_VALID, BUSY, DONE}), 32'd0);
    chk("rst_row_idx", 32'(ROW_IDX), 32'd0);
    chk("rst_pc", 32'(PC_INS), 32'd0);
    chk("rst_instr_reg", INSTR_REG, 32'd0);

    // Program {5,7,0} with EXEC_DONE three cycles after EXEC_START
    do_reset();
    prog[0] = 32'd5; prog[1] = 32'd7; prog[2] = 32'd0;
    exec_dly = 3; clr_stats(); go = 1;
    run_to_done(3000, "prog_done");
    chk("prog_exec_pulses", 32'(st_exec), 32'd2);
    chk("prog_rows_out", 32'(st_rows), 32'd32);
    chk("prog_pc", 32'(PC_INS), 32'd2);
    chk("prog_instr_reg", INSTR_REG, 32'd0);
    go = 1; step(); step();
    chk("restart_pc", 32'(PC_INS), 32'd0);
    chk("restart_flags", 32'({BUSY, DONE, MATAB_SEL}), 32'b100);

    // Writeback stall on row 3 for 4 cycles
    do_reset();
    for (int i = 0; i < 256; i++) prog[i] = 32'h1;
    prog[0] = 32'd9; prog[1] = 32'd0;
    clr_stats(); stall3 = 1; stall_left = 4; go = 1;
    run_to_done(3000, "stall_done");
    chk("stall_rows_out", 32'(st_rows), 32'd16);
    chk("stall_cycles_row3", 32'(st_stall3), 32'd4);
    stall3 = 0;

    // PC wrap from 255 to 0
    do_reset();
    for (int i = 0; i < 256; i++) prog[i] = $urandom | 32'h1;
    wrap_halt = 1; saw_top = 0; go = 1;
    run_to_done(20000, "wrap_done");
    chk("wrap_saw_pc255", 32'(saw_top), 32'd1);
    chk("wrap_pc", 32'(PC_INS), 32'd0);
    wrap_halt = 0;

    // Randomized programs, handshakes and ignored-input noise
    for (int r = 0; r < 10; r++) begin
      int len;
      do_reset();
      mat_p = $urandom_range(100, 30); rdy_p = $urandom_range(100, 30);
      iv_p = $urandom_range(100, 20); exec_dly = $urandom_range(4, 0);
      start_p = $urandom_range(10, 0); noise = 1;
      len = $urandom_range(6, 1);
      for (int i = 0; i < 256; i++) prog[i] = $urandom | 32'h1;
      prog[len] = 32'd0;
      go = 1;
      run_to_done(4000, "rand_done");
      start_p = 0; go = 1; step(); step();
      run_to_done(4000, "rand_rerun_done");
    end

    noise = 0;
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
